// File: rtl/rfdc_timing_pkg.sv
// Register map, bit positions and FSM/status encodings for the RFDC timing
// register block, shared by the NCO reset sequencer and its sub-modules.
package rfdc_timing_pkg;

  // Register offsets relative to the block base address
  localparam logic [19:0] NCO_RESET_REG     = 20'h00;
  localparam logic [19:0] GEARBOX_RESET_REG = 20'h04;

  // NCO_RESET_REG bit positions
  localparam int NCO_RESET_START   = 0;
  localparam int NCO_RESET_DONE    = 1;
  localparam int NCO_SYNC_FAILED   = 8;
  localparam int SYSREF_WAIT_LSB   = 16;
  localparam int SYSREF_WAIT_MSB   = 23;
  localparam int WRITE_SYSREF_WAIT = 24;

  // GEARBOX_RESET_REG bit positions
  localparam int ADC_RESET = 0;
  localparam int DAC_RESET = 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WR_NCO  = 4'd1,
    WAIT_WR = 4'd2,
    GAP     = 4'd3,
    RD_ST   = 4'd4,
    WAIT_RD = 4'd5,
    GB_WR   = 4'd6,
    WAIT_GB = 4'd7,
    FIN     = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_SYNC_FAILED  = 2'd1,
    ST_ACK_TIMEOUT  = 2'd2,
    ST_POLL_TIMEOUT = 2'd3
  } seq_status_t;

  // Single write that both loads SYSREF_WAIT and kicks off the NCO reset
  function automatic logic [31:0] nco_start_word(input logic [7:0] sysref_wait);
    logic [31:0] w;
    w = '0;
    w[NCO_RESET_START] = 1'b1;
    w[WRITE_SYSREF_WAIT] = 1'b1;
    w[SYSREF_WAIT_MSB:SYSREF_WAIT_LSB] = sysref_wait;
    return w;
  endfunction

  // Resets both ADC and DAC gearboxes together
  function automatic logic [31:0] gearbox_reset_word();
    logic [31:0] w;
    w = '0;
    w[ADC_RESET] = 1'b1;
    w[DAC_RESET] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/ctrlport_xact_timer.sv
// Per-transaction CtrlPort ack timeout. load restarts the count on every
// request strobe; expire is high once ACK_TIMEOUT cycles have passed since
// the strobe without a new load.
module ctrlport_xact_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

  logic [CW-1:0] cnt;

  // Zero means idle; counts up from 1 after a strobe and saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(1);
    end else if (cnt != '0 && cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == LIMIT);

endmodule

// File: rtl/rfdc_nco_reset_sequencer.sv
// CtrlPort initiator running the RFDC timing NCO reset sequence: one write of
// SYSREF_WAIT plus the start strobe, then status polling until DONE,
// SYNC_FAILED, a poll-count limit or an ack timeout.
// Optional feature macro: RFDC_SEQ_GEARBOX_RESET_EN adds a gearbox reset
// write after DONE.
module rfdc_nco_reset_sequencer
  import rfdc_timing_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR   = 20'h0,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          POLL_GAP    = 16,
  parameter int          MAX_POLLS   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  sysref_wait,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic        m_ctrlport_req_wr,
  output logic        m_ctrlport_req_rd,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [31:0] m_ctrlport_req_data,
  input  logic        m_ctrlport_resp_ack,
  input  logic [1:0]  m_ctrlport_resp_status,
  input  logic [31:0] m_ctrlport_resp_data
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS);

  seq_state_t  state;
  seq_status_t status_q;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic ack_err;
  logic ack_expire;
  logic unused_resp_bits;

  assign ack_err = m_ctrlport_resp_ack && (m_ctrlport_resp_status != 2'b00);
  assign status  = status_q;
  assign unused_resp_bits = ^{m_ctrlport_resp_data[31:9], m_ctrlport_resp_data[7:2],
                              m_ctrlport_resp_data[0]};

  ctrlport_xact_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_xact_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (m_ctrlport_req_wr | m_ctrlport_req_rd),
    .expire (ack_expire)
  );

  // Sequencer FSM; strobes and done are registered so they line up with their state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      status_q            <= ST_OK;
      busy                <= 1'b0;
      done                <= 1'b0;
      gap_cnt             <= '0;
      poll_cnt            <= '0;
      m_ctrlport_req_wr   <= 1'b0;
      m_ctrlport_req_rd   <= 1'b0;
      m_ctrlport_req_addr <= '0;
      m_ctrlport_req_data <= '0;
    end else begin
      m_ctrlport_req_wr <= 1'b0;
      m_ctrlport_req_rd <= 1'b0;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy                <= 1'b1;
            status_q            <= ST_OK;
            gap_cnt             <= '0;
            poll_cnt            <= '0;
            m_ctrlport_req_wr   <= 1'b1;
            m_ctrlport_req_addr <= BASE_ADDR + NCO_RESET_REG;
            m_ctrlport_req_data <= nco_start_word(sysref_wait);
            state               <= WR_NCO;
          end
        end
        WR_NCO: state <= WAIT_WR;
        WAIT_WR: begin
          if (m_ctrlport_resp_ack) begin
            if (ack_err) begin
              status_q <= ST_POLL_TIMEOUT;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else if (ack_expire) begin
            status_q <= ST_ACK_TIMEOUT;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            m_ctrlport_req_rd   <= 1'b1;
            m_ctrlport_req_addr <= BASE_ADDR + NCO_RESET_REG;
            state               <= RD_ST;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        RD_ST: begin
          poll_cnt <= poll_cnt + PW'(1);
          state    <= WAIT_RD;
        end
        WAIT_RD: begin
          if (m_ctrlport_resp_ack) begin
            if (ack_err) begin
              status_q <= ST_POLL_TIMEOUT;
              done     <= 1'b1;
              state    <= FIN;
            end else if (m_ctrlport_resp_data[NCO_SYNC_FAILED]) begin
              status_q <= ST_SYNC_FAILED;
              done     <= 1'b1;
              state    <= FIN;
            end else if (m_ctrlport_resp_data[NCO_RESET_DONE]) begin
              status_q <= ST_OK;
`ifdef RFDC_SEQ_GEARBOX_RESET_EN
              m_ctrlport_req_wr   <= 1'b1;
              m_ctrlport_req_addr <= BASE_ADDR + GEARBOX_RESET_REG;
              m_ctrlport_req_data <= gearbox_reset_word();
              state               <= GB_WR;
`else
              done  <= 1'b1;
              state <= FIN;
`endif
            end else if (poll_cnt == POLL_LAST) begin
              status_q <= ST_POLL_TIMEOUT;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else if (ack_expire) begin
            status_q <= ST_ACK_TIMEOUT;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
`ifdef RFDC_SEQ_GEARBOX_RESET_EN
        GB_WR: state <= WAIT_GB;
        WAIT_GB: begin
          if (m_ctrlport_resp_ack) begin
            if (ack_err) begin
              status_q <= ST_POLL_TIMEOUT;
            end
            done  <= 1'b1;
            state <= FIN;
          end else if (ack_expire) begin
            status_q <= ST_ACK_TIMEOUT;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
`endif
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
